// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default operand width for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// 1-bit full adder cell.
// Latency: combinational.
// Backpressure: none, pure logic.
module Full_Adder (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first through one full adder cell.
// Latency: out_valid rises WIDTH cycles after accept; initiation interval WIDTH+2.
// Backpressure: result held in DONE until out_ready; in_ready high only in IDLE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_sum;
    logic             cell_carry;

    Full_Adder u_fa (
        .sum   (cell_sum),
        .carry (cell_carry),
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry)
    );

    assign in_ready = (state == ST_IDLE);
    assign sum_out  = sum_sr;
    assign cout_out = carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin_in;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    carry  <= cell_carry;
                    sum_sr <= WIDTH'({cell_sum, sum_sr} >> 1);
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 3 and 1 with a shared result scoreboard.
module tb_serial_adder;

    typedef struct {
        logic [32:0] exp;
        int          acc;
    } sb_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          n_checks;
    int          n_fail;
    sb_t         sbq [$];

    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] a_in      [3];
    logic [31:0] b_in      [3];
    logic        cin_in    [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] sum_out   [3];
    logic        cout_out  [3];
    logic        busy      [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : ((g == 1) ? 3 : 1);
        logic [W-1:0] s;
        logic         ov_prev;
        sb_t          e;

        serial_adder #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a_in      (a_in[g][W-1:0]),
            .b_in      (b_in[g][W-1:0]),
            .cin_in    (cin_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .sum_out   (s),
            .cout_out  (cout_out[g]),
            .busy      (busy[g])
        );
        assign sum_out[g] = 32'(s);

        // Output monitor: latency on the rising edge of out_valid, value on handshake.
        always @(negedge clk) begin
            if (!rst_n) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid[g] && !ov_prev) begin
                    if (sbq.size() == 0) bound_fail($sformatf("unexpected_result_w%0d", W));
                    else chk($sformatf("latency_w%0d", W), 64'(cyc - sbq[0].acc), 64'(W));
                end
                if (out_valid[g] && out_ready[g] && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk($sformatf("result_w%0d", W),
                        (64'(cout_out[g]) << W) | 64'(sum_out[g]), 64'(e.exp));
                end
                ov_prev = out_valid[g];
            end
        end
    end

    task automatic send(input int g, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [32:0] exp, input bit keep,
                        output int acc);
        acc = -1;
        in_valid[g] = 1'b1;
        a_in[g]     = a;
        b_in[g]     = b;
        cin_in[g]   = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready[g]) begin
                acc = cyc + 1;
                sbq.push_back('{exp: exp, acc: acc});
                @(posedge clk);
                #1;
                if (!keep) in_valid[g] = 1'b0;
                return;
            end
        end
        in_valid[g] = 1'b0;
        bound_fail("accept_timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) bound_fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        int   acc;
        int   prev_acc;
        bit   seen;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, exp: 9'h096};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp: 9'h100};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp: 9'h1FF};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp: 9'h000};
        vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, exp: 9'h001};
        vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp: 9'h100};
        vecs[6] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, exp: 9'h100};
        vecs[7] = '{a: 8'h12, b: 8'h34, cin: 1'b1, exp: 9'h047};

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b1;
            a_in[g]      = '0;
            b_in[g]      = '0;
            cin_in[g]    = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_in_ready",  64'(in_ready[g]),  64'd1);
            chk("rst_out_valid", 64'(out_valid[g]), 64'd0);
            chk("rst_busy",      64'(busy[g]),      64'd0);
            chk("rst_sum_out",   64'(sum_out[g]),   64'd0);
            chk("rst_cout_out",  64'(cout_out[g]),  64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors, one at a time
        foreach (vecs[i]) begin
            send(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, 33'(vecs[i].exp), 1'b0, acc);
            drain();
        end

        // Consumer stalls for 5 cycles; new operands during the stall are ignored
        out_ready[0] = 1'b0;
        send(0, 32'hC3, 32'h0F, 1'b1, 33'h0D3, 1'b0, acc);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid[0];
        end
        if (!seen) bound_fail("stall_wait_valid");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", 64'(out_valid[0]), 64'd1);
            chk("stall_sum",       64'(sum_out[0]),   64'h0D3);
            chk("stall_cout",      64'(cout_out[0]),  64'd0);
            chk("stall_in_ready",  64'(in_ready[0]),  64'd0);
            in_valid[0] = 1'b1;
            a_in[0]     = 32'h11;
            b_in[0]     = 32'h22;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready",  64'(in_ready[0]),  64'd1);
        chk("release_out_valid", 64'(out_valid[0]), 64'd0);
        chk("release_sb_empty",  64'(sbq.size()),   64'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("ignored_op_no_result", 64'(out_valid[0]), 64'd0);

        // Reset on the third SHIFT edge aborts the operation
        send(0, 32'h77, 32'h88, 1'b0, 33'h0FF, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", 64'(out_valid[0]), 64'd0);
        chk("abort_busy",      64'(busy[0]),      64'd0);
        chk("abort_in_ready",  64'(in_ready[0]),  64'd1);
        chk("abort_sum",       64'(sum_out[0]),   64'd0);
        sbq.delete();
        rst_n = 1'b1;
        send(0, 32'h01, 32'h02, 1'b0, 33'h003, 1'b0, acc);
        drain();

        // Back-to-back with in_valid and out_ready held high
        prev_acc = -1;
        for (int i = 0; i < 5; i++) begin
            send(0, 32'(8'h31 * (i + 1)), 32'(8'h9D + i), 1'(i), 33'(9'(8'h31 * (i + 1)) + 9'(8'h9D + i) + 9'(i % 2)), (i != 4), acc);
            if (prev_acc >= 0) chk("b2b_interval", 64'(acc - prev_acc), 64'd10);
            prev_acc = acc;
        end
        drain();
        repeat (12) @(posedge clk);
        #1;
        chk("b2b_no_extra", 64'(out_valid[0]), 64'd0);

        // Exhaustive at WIDTH=3 and WIDTH=1, streamed back-to-back
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    send(1, 32'(a), 32'(b), 1'(c), 33'(a + b + c), !(a == 7 && b == 7 && c == 1), acc);
        drain();
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++)
                    send(2, 32'(a), 32'(b), 1'(c), 33'(a + b + c), !(a == 1 && b == 1 && c == 1), acc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
